// File: rtl/pwrseq_rail_slave_pkg.sv
// Shared state codes, rail indices, fault type codes and the state-to-enable mask table
// for the power-sequencer rail slave.
package pwrseq_rail_slave_pkg;

  localparam int unsigned NUM_RAILS = 4;

  localparam logic [5:0] SM_RESET        = 6'd0;
  localparam logic [5:0] SM_EN_P0V8      = 6'd1;
  localparam logic [5:0] SM_EN_P1V8      = 6'd2;
  localparam logic [5:0] SM_EN_DDR       = 6'd3;
  localparam logic [5:0] SM_EN_PCIE      = 6'd4;
  localparam logic [5:0] SM_PCIE_RESET   = 6'd5;
  localparam logic [5:0] SM_CPU_RESET    = 6'd6;
  localparam logic [5:0] SM_WAIT_POWEROK = 6'd7;
  localparam logic [5:0] SM_STEADY_PWROK = 6'd8;
  localparam logic [5:0] SM_CRITICAL_FAIL = 6'd9;
  localparam logic [5:0] SM_DIS_PCIE     = 6'd10;
  localparam logic [5:0] SM_DIS_DDR      = 6'd11;
  localparam logic [5:0] SM_DIS_P1V8     = 6'd12;
  localparam logic [5:0] SM_DIS_P0V8     = 6'd13;

  localparam int unsigned RAIL_P0V8 = 0;
  localparam int unsigned RAIL_P1V8 = 1;
  localparam int unsigned RAIL_DDR  = 2;
  localparam int unsigned RAIL_PCIE = 3;

  localparam logic [1:0] FT_NONE  = 2'd0;
  localparam logic [1:0] FT_RT    = 2'd1;
  localparam logic [1:0] FT_PO    = 2'd2;
  localparam logic [1:0] FT_STUCK = 2'd3;

  function automatic logic [NUM_RAILS-1:0] target_mask(input logic [5:0] sm);
    logic [NUM_RAILS-1:0] mask;
    case (sm)
      SM_EN_P0V8:                              mask = 4'b0001;
      SM_EN_P1V8:                              mask = 4'b0011;
      SM_EN_DDR:                               mask = 4'b0111;
      SM_EN_PCIE, SM_PCIE_RESET, SM_CPU_RESET,
      SM_WAIT_POWEROK, SM_STEADY_PWROK,
      SM_CRITICAL_FAIL:                        mask = 4'b1111;
      SM_DIS_PCIE:                             mask = 4'b0111;
      SM_DIS_DDR:                              mask = 4'b0011;
      SM_DIS_P1V8:                             mask = 4'b0001;
      default:                                 mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pwrseq_rail_slave_pg_filter.sv
// Single-rail power-good path: 2-flop synchroniser followed by a t1us-sampled
// debounce that flips the filtered level after FILTER_US consecutive disagreeing samples.
module pwrseq_rail_slave_pg_filter #(
  parameter int unsigned FILTER_US = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic t1us,
  input  logic pg_raw,
  output logic pg_filt
);

  logic       sync1, sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= 4'd0;
      pg_filt <= 1'b0;
    end else begin
      sync1 <= pg_raw;
      sync2 <= sync1;
      if (t1us) begin
        if (sync2 != pg_filt) begin
          if (cnt == 4'(FILTER_US - 1)) begin
            pg_filt <= sync2;
            cnt     <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end else begin
          // an agreeing sample breaks the run of disagreeing ones
          cnt <= 4'd0;
        end
      end
    end
  end

endmodule

// File: rtl/pwrseq_rail_slave.sv
// Power-sequencer rail slave: decodes master state to rail enables/resets, filters PG and
// latches faults. Optional fault logging is enabled by defining PWRSEQ_FAULT_LOG_EN.
module pwrseq_rail_slave
  import pwrseq_rail_slave_pkg::*;
#(
  parameter int unsigned          PG_FILTER_US  = 4,
  parameter logic [NUM_RAILS-1:0] NONRECOV_MASK = 4'b0001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 t1us,
  input  logic [5:0]           power_seq_sm,
  input  logic                 dc_on_wait_complete,
  input  logic                 fault_clear,
  input  logic [NUM_RAILS-1:0] pg_in,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 pcie_perst_n,
  output logic                 cpu_rst_n,
  output logic                 pgd_so_far,
  output logic                 any_pwr_fault_det,
  output logic                 any_lim_recov_fault,
  output logic                 any_non_recov_fault,
  output logic [NUM_RAILS-1:0] fault_latch
`ifdef PWRSEQ_FAULT_LOG_EN
  ,
  output logic [1:0]           first_fault_rail,
  output logic [1:0]           first_fault_type,
  output logic [7:0]           fault_count
`endif
);

  logic [NUM_RAILS-1:0] pg_filt;
  logic [NUM_RAILS-1:0] good_seen;
  logic [NUM_RAILS-1:0] rt_drop, po_fail, stuck_on, fault_set, fault_next;
  logic                 stuck_state;

  for (genvar i = 0; i < NUM_RAILS; i++) begin : g_pg
    pwrseq_rail_slave_pg_filter #(
      .FILTER_US(PG_FILTER_US)
    ) u_filter (
      .clk    (clk),
      .reset  (reset),
      .t1us   (t1us),
      .pg_raw (pg_in[i]),
      .pg_filt(pg_filt[i])
    );
  end

  always_comb begin
    stuck_state = (power_seq_sm == SM_RESET) ||
                  ((power_seq_sm >= SM_DIS_PCIE) && (power_seq_sm <= SM_DIS_P0V8));
    rt_drop     = rail_en & good_seen & ~pg_filt;
    po_fail     = rail_en & ~good_seen & {NUM_RAILS{dc_on_wait_complete}};
    stuck_on    = ~rail_en & pg_filt & {NUM_RAILS{dc_on_wait_complete & stuck_state}};
    fault_set   = rt_drop | po_fail | stuck_on;
    // a new set in the same clk as fault_clear wins
    fault_next  = (fault_latch & ~{NUM_RAILS{fault_clear}}) | fault_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rail_en      <= '0;
      pcie_perst_n <= 1'b0;
      cpu_rst_n    <= 1'b0;
      good_seen    <= '0;
      pgd_so_far   <= 1'b0;
      fault_latch  <= '0;
    end else begin
      rail_en      <= target_mask(power_seq_sm);
      pcie_perst_n <= (power_seq_sm >= SM_CPU_RESET) && (power_seq_sm <= SM_STEADY_PWROK);
      cpu_rst_n    <= (power_seq_sm >= SM_WAIT_POWEROK) && (power_seq_sm <= SM_STEADY_PWROK);
      good_seen    <= rail_en & (good_seen | pg_filt);
      pgd_so_far   <= (|rail_en) && (&(~rail_en | pg_filt));
      fault_latch  <= fault_next;
    end
  end

  assign any_pwr_fault_det   = |fault_latch;
  assign any_lim_recov_fault = |(fault_latch & ~NONRECOV_MASK);
  assign any_non_recov_fault = |(fault_latch & NONRECOV_MASK);

`ifdef PWRSEQ_FAULT_LOG_EN
  logic [1:0] ff_rail_d, ff_type_d;
  logic       any_det_q;

  // lowest-index setting rail; RT takes priority over PO over STUCK on that rail
  always_comb begin
    ff_rail_d = 2'd0;
    ff_type_d = FT_NONE;
    for (int i = NUM_RAILS - 1; i >= 0; i--) begin
      if (fault_set[i]) begin
        ff_rail_d = 2'(i);
        ff_type_d = rt_drop[i] ? FT_RT : (po_fail[i] ? FT_PO : FT_STUCK);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_fault_rail <= 2'd0;
      first_fault_type <= FT_NONE;
      fault_count      <= 8'd0;
      any_det_q        <= 1'b0;
    end else begin
      any_det_q <= any_pwr_fault_det;
      if (any_pwr_fault_det && !any_det_q && (fault_count != 8'hff)) begin
        fault_count <= fault_count + 8'd1;
      end
      if (fault_clear) begin
        first_fault_rail <= ff_rail_d;
        first_fault_type <= ff_type_d;
      end else if ((fault_latch == '0) && (fault_set != '0)) begin
        first_fault_rail <= ff_rail_d;
        first_fault_type <= ff_type_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pwrseq_rail_slave.sv
// Directed self-checking bench for pwrseq_rail_slave; t1us is one clk every 10 clks.
module tb_pwrseq_rail_slave;
  import pwrseq_rail_slave_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       t1us;
  logic [5:0] power_seq_sm;
  logic       dc_on_wait_complete;
  logic       fault_clear;
  logic [3:0] pg_in;
  logic [3:0] rail_en;
  logic       pcie_perst_n, cpu_rst_n, pgd_so_far;
  logic       any_pwr_fault_det, any_lim_recov_fault, any_non_recov_fault;
  logic [3:0] fault_latch;
`ifdef PWRSEQ_FAULT_LOG_EN
  logic [1:0] first_fault_rail, first_fault_type;
  logic [7:0] fault_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwrseq_rail_slave #(
    .PG_FILTER_US (4),
    .NONRECOV_MASK(4'b0001)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .t1us               (t1us),
    .power_seq_sm       (power_seq_sm),
    .dc_on_wait_complete(dc_on_wait_complete),
    .fault_clear        (fault_clear),
    .pg_in              (pg_in),
    .rail_en            (rail_en),
    .pcie_perst_n       (pcie_perst_n),
    .cpu_rst_n          (cpu_rst_n),
    .pgd_so_far         (pgd_so_far),
    .any_pwr_fault_det  (any_pwr_fault_det),
    .any_lim_recov_fault(any_lim_recov_fault),
    .any_non_recov_fault(any_non_recov_fault),
    .fault_latch        (fault_latch)
`ifdef PWRSEQ_FAULT_LOG_EN
    ,
    .first_fault_rail   (first_fault_rail),
    .first_fault_type   (first_fault_type),
    .fault_count        (fault_count)
`endif
  );

  initial begin
    t1us = 1'b0;
    forever begin
      repeat (9) begin
        @(posedge clk);
        #1 t1us = 1'b0;
      end
      @(posedge clk);
      #1 t1us = 1'b1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_clear();
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
  endtask

  task automatic step_state(input logic [5:0] sm, input logic [3:0] exp_en, input string tag);
    power_seq_sm = sm;
    tick();
    chk(tag, 32'(rail_en), 32'(exp_en));
  endtask

  logic pgd_held;

  initial begin
    reset = 1'b1;
    power_seq_sm = SM_RESET;
    dc_on_wait_complete = 1'b0;
    fault_clear = 1'b0;
    pg_in = 4'b0000;
    tick(3);
    chk("reset_rail_en", 32'(rail_en), 32'h0);
    chk("reset_perst", 32'(pcie_perst_n), 32'h0);
    chk("reset_cpu", 32'(cpu_rst_n), 32'h0);
    chk("reset_pgd", 32'(pgd_so_far), 32'h0);
    chk("reset_latch", 32'(fault_latch), 32'h0);
    reset = 1'b0;
    tick(2);

    // power-up ramp, each PG rising 10us after its enable
    step_state(SM_EN_P0V8, 4'b0001, "up_en1");
    tick(100); pg_in[0] = 1'b1; tick(100);
    step_state(SM_EN_P1V8, 4'b0011, "up_en2");
    tick(100); pg_in[1] = 1'b1; tick(100);
    step_state(SM_EN_DDR, 4'b0111, "up_en3");
    tick(100); pg_in[2] = 1'b1; tick(100);
    step_state(SM_EN_PCIE, 4'b1111, "up_en4");
    tick(100);
    chk("pgd_before_last_pg", 32'(pgd_so_far), 32'h0);
    pg_in[3] = 1'b1;
    tick(20);
    chk("pgd_not_early", 32'(pgd_so_far), 32'h0);
    for (int i = 0; i < 60 && !pgd_so_far; i++) tick();
    chk("pgd_rises", 32'(pgd_so_far), 32'h1);
    step_state(SM_PCIE_RESET, 4'b1111, "st5_en");
    chk("st5_perst", 32'(pcie_perst_n), 32'h0);
    step_state(SM_CPU_RESET, 4'b1111, "st6_en");
    chk("st6_perst", 32'(pcie_perst_n), 32'h1);
    chk("st6_cpu", 32'(cpu_rst_n), 32'h0);
    step_state(SM_WAIT_POWEROK, 4'b1111, "st7_en");
    chk("st7_cpu", 32'(cpu_rst_n), 32'h1);
    step_state(SM_STEADY_PWROK, 4'b1111, "st8_en");
    chk("no_fault_after_ramp", 32'(fault_latch), 32'h0);

    // runtime drop of DDR PG for 20us
    pg_in[2] = 1'b0;
    tick(80);
    chk("rt_latch", 32'(fault_latch), 32'h4);
    chk("rt_lim", 32'(any_lim_recov_fault), 32'h1);
    chk("rt_nonrec", 32'(any_non_recov_fault), 32'h0);
    chk("rt_any", 32'(any_pwr_fault_det), 32'h1);
    chk("rt_en_kept", 32'(rail_en), 32'hf);
`ifdef PWRSEQ_FAULT_LOG_EN
    chk("log_first_rail", 32'(first_fault_rail), 32'h2);
    chk("log_first_type", 32'(first_fault_type), 32'(FT_RT));
`endif
    tick(120);
    pg_in[2] = 1'b1;
    tick(100);
    pulse_clear();
    chk("rt_cleared", 32'(fault_latch), 32'h0);
    chk("rt_cleared_any", 32'(any_pwr_fault_det), 32'h0);
    chk("pgd_restored", 32'(pgd_so_far), 32'h1);

    // 2us glitch on P1V8 is filtered out
    pg_in[1] = 1'b0;
    tick(20);
    pg_in[1] = 1'b1;
    pgd_held = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!pgd_so_far) pgd_held = 1'b0;
    end
    chk("glitch_pgd_held", 32'(pgd_held), 32'h1);
    chk("glitch_no_fault", 32'(fault_latch), 32'h0);

    // clear while the drop condition is still setting: set wins
    pg_in[1] = 1'b0;
    tick(80);
    chk("rt1_latch", 32'(fault_latch), 32'h2);
`ifdef PWRSEQ_FAULT_LOG_EN
    chk("log_count2", 32'(fault_count), 32'h2);
`endif
    pulse_clear();
    chk("set_wins_clear", 32'(fault_latch), 32'h2);
    pg_in[1] = 1'b1;
    tick(100);
    pulse_clear();
    chk("rt1_cleared", 32'(fault_latch), 32'h0);

    // power-down with PCIE PG stuck high
    power_seq_sm = SM_DIS_PCIE;
    dc_on_wait_complete = 1'b1;
    tick();
    chk("dis_pcie_en", 32'(rail_en), 32'h7);
    tick();
    dc_on_wait_complete = 1'b0;
    chk("stuck_latch", 32'(fault_latch), 32'h8);
    chk("stuck_lim", 32'(any_lim_recov_fault), 32'h1);
    chk("stuck_nonrec", 32'(any_non_recov_fault), 32'h0);
    step_state(SM_DIS_DDR, 4'b0011, "dis_ddr_en");
    step_state(SM_DIS_P1V8, 4'b0001, "dis_p1v8_en");
    step_state(SM_DIS_P0V8, 4'b0000, "dis_p0v8_en");
    pg_in = 4'b0000;
    tick(100);
    pulse_clear();
    chk("stuck_cleared", 32'(fault_latch), 32'h0);

    // power-on failure on P0V8 is non-recoverable
    step_state(SM_EN_P0V8, 4'b0001, "po_en");
    dc_on_wait_complete = 1'b1;
    tick();
    dc_on_wait_complete = 1'b0;
    chk("po_latch", 32'(fault_latch), 32'h1);
    chk("po_nonrec", 32'(any_non_recov_fault), 32'h1);
    chk("po_lim", 32'(any_lim_recov_fault), 32'h0);

    // asynchronous reset from steady state
    power_seq_sm = SM_STEADY_PWROK;
    tick(2);
    chk("pre_rst_en", 32'(rail_en), 32'hf);
    chk("pre_rst_perst", 32'(pcie_perst_n), 32'h1);
    chk("pre_rst_cpu", 32'(cpu_rst_n), 32'h1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_en", 32'(rail_en), 32'h0);
    chk("async_rst_perst", 32'(pcie_perst_n), 32'h0);
    chk("async_rst_cpu", 32'(cpu_rst_n), 32'h0);
    chk("async_rst_latch", 32'(fault_latch), 32'h0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
